// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX stage of the RV32I pipeline.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_OP_W   = 4;
  localparam int unsigned PIPE_REG_W  = 5;

  localparam logic [PIPE_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [PIPE_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [PIPE_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [PIPE_OP_W-1:0] ALU_EQ  = 4'b1000;

  // Operand source selected by the forwarding unit.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Everything the ID/EX register holds.
  typedef struct packed {
    logic                   valid;
    logic [PIPE_DATA_W-1:0] pc;
    logic [PIPE_DATA_W-1:0] rs1_data;
    logic [PIPE_DATA_W-1:0] rs2_data;
    logic [PIPE_DATA_W-1:0] imm;
    logic [PIPE_REG_W-1:0]  rs1;
    logic [PIPE_REG_W-1:0]  rs2;
    logic [PIPE_REG_W-1:0]  rd;
    logic                   alu_src;
    logic [PIPE_OP_W-1:0]   alu_op;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic                   branch;
  } id_ex_t;

endpackage

// File: rtl/forwarding_unit.sv
// Selects the freshest value for each EX source register from EX/MEM or MEM/WB.
module forwarding_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  mwb_reg_write,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  output fwd_sel_e              fwd_a,
  output fwd_sel_e              fwd_b
);

  logic exm_ok, mwb_ok;

  // A producer only forwards when it writes a real (non-x0) register.
  always_comb begin
    exm_ok = exm_reg_write && (exm_rd != '0);
    mwb_ok = mwb_reg_write && (mwb_rd != '0);
  end

  // EX/MEM is younger than MEM/WB, so it wins when both match.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (exm_ok && (exm_rd == ex_rs1))      fwd_a = FWD_EXMEM;
    else if (mwb_ok && (mwb_rd == ex_rs1)) fwd_a = FWD_MEMWB;
    if (exm_ok && (exm_rd == ex_rs2))      fwd_b = FWD_EXMEM;
    else if (mwb_ok && (mwb_rd == ex_rs2)) fwd_b = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_mem_to_reg,
  input  logic                     id_branch,
  input  logic                     exm_reg_write,
  input  logic [REG_ADDR_W-1:0]    exm_rd,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic                     mwb_reg_write,
  input  logic [REG_ADDR_W-1:0]    mwb_rd,
  input  logic [DATA_WIDTH-1:0]    mwb_result,
  output logic                     load_use_stall,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    ex_src_a,
  output logic [DATA_WIDTH-1:0]    ex_src_b,
  output logic [OPCODE_LENGTH-1:0] ex_operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_mem_to_reg,
  output logic                     ex_branch
);

  // id_ex_t field widths come from pipe_pkg; parameters must match them.
  id_ex_t   ex_d, ex_q;
  fwd_sel_e fwd_a, fwd_b;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

  // Load in EX feeding a source of the instruction in ID; a flush makes it moot.
  always_comb begin
    load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                     ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && !flush;
  end

  // Next-state with priority flush > stall > load-use bubble > load.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use_stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.pc         = id_pc;
      ex_d.rs1_data   = id_rs1_data;
      ex_d.rs2_data   = id_rs2_data;
      ex_d.imm        = id_imm;
      ex_d.rs1        = id_rs1;
      ex_d.rs2        = id_rs2;
      ex_d.rd         = id_rd;
      ex_d.alu_src    = id_alu_src;
      ex_d.alu_op     = id_alu_op;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.branch     = id_branch;
    end
  end

  // Stage register; zero is a bubble with operation ALU_AND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  forwarding_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_forwarding_unit (
    .ex_rs1        (ex_q.rs1),
    .ex_rs2        (ex_q.rs2),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  // Operand muxes driven by the forwarding selects.
  always_comb begin
    unique case (fwd_a)
      FWD_EXMEM: fwd_rs1 = exm_result;
      FWD_MEMWB: fwd_rs1 = mwb_result;
      default:   fwd_rs1 = ex_q.rs1_data;
    endcase
    unique case (fwd_b)
      FWD_EXMEM: fwd_rs2 = exm_result;
      FWD_MEMWB: fwd_rs2 = mwb_result;
      default:   fwd_rs2 = ex_q.rs2_data;
    endcase
  end

  // Outputs to the ALU and downstream; control gated so an invalid slot never acts.
  always_comb begin
    ex_valid      = ex_q.valid;
    ex_src_a      = fwd_rs1;
    ex_src_b      = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    ex_store_data = fwd_rs2;
    ex_operation  = ex_q.alu_op;
    ex_pc         = ex_q.pc;
    ex_rd         = ex_q.rd;
    ex_reg_write  = ex_q.valid & ex_q.reg_write;
    ex_mem_read   = ex_q.valid & ex_q.mem_read;
    ex_mem_write  = ex_q.valid & ex_q.mem_write;
    ex_mem_to_reg = ex_q.valid & ex_q.mem_to_reg;
    ex_branch     = ex_q.valid & ex_q.branch;
  end

endmodule
